// File: rtl/tx_fifo.sv
// Transmit FIFO between an APB write port and the serial transmit logic.
// Storage is plain registers so the array can be cleared asynchronously.
module tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  NextWord,
    output logic [DATA_WIDTH-1:0] TxData,
    output logic                  TxValid,
    output logic                  SSPTXINTR
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic wr_req;
    logic is_full;
    logic is_empty;
    logic write_blocked;
    logic wr_en;
    logic rd_en;

    logic [DATA_WIDTH-1:0] mem_rd [DEPTH];

    always_comb begin
        wr_req   = PSEL && PWRITE;
        is_full  = (count_q == FULL_COUNT);
        is_empty = (count_q == '0);
        // A write that hits a full FIFO freezes the whole edge, including any pop.
        write_blocked = wr_req && is_full;
        wr_en         = wr_req && !is_full;
        rd_en         = NextWord && !is_empty && !write_blocked;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = PWDATA;
                end
            end

            always_ff @(posedge PCLK or posedge CLEAR) begin
                if (CLEAR) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign mem_rd[gi] = entry_q;
        end
    endgenerate

    // Head word and flags depend only on registered state.
    assign TxData    = mem_rd[rd_ptr_q];
    assign TxValid   = !is_empty;
    assign SSPTXINTR = is_full;

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based model of the FIFO rules.
module tb_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          PCLK = 1'b0;
    logic          CLEAR;
    logic          PSEL;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          NextWord;
    logic [DW-1:0] TxData;
    logic          TxValid;
    logic          SSPTXINTR;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];

    tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .NextWord  (NextWord),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .SSPTXINTR (SSPTXINTR)
    );

    always #20 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the model; head data is meaningful only when non-empty.
    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 32'(TxValid), 32'(model_q.size() != 0));
        chk({tag, ".full"}, 32'(SSPTXINTR), 32'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            chk({tag, ".data"}, 32'(TxData), 32'(model_q[0]));
        end
        $display("[%0t] %s size=%0d valid=%0b full=%0b data=%02h", $time, tag,
                 model_q.size(), TxValid, SSPTXINTR, TxData);
    endtask

    // One clock: drive at the falling edge, apply the FIFO rules at the rising edge.
    task automatic step(input logic psel, input logic pwrite, input logic [DW-1:0] data,
                        input logic next, input string tag);
        bit wreq;
        @(negedge PCLK);
        PSEL     = psel;
        PWRITE   = pwrite;
        PWDATA   = data;
        NextWord = next;
        @(posedge PCLK);
        wreq = psel && pwrite;
        if (!(wreq && model_q.size() == DEPTH)) begin
            if (next && model_q.size() > 0) begin
                void'(model_q.pop_front());
            end
            if (wreq) begin
                model_q.push_back(data);
            end
        end
        #1;
        PSEL     = 1'b0;
        PWRITE   = 1'b0;
        NextWord = 1'b0;
        check_state(tag);
    endtask

    initial begin
        CLEAR    = 1'b1;
        PSEL     = 1'b0;
        PWRITE   = 1'b0;
        PWDATA   = '0;
        NextWord = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge PCLK);
        #1;
        chk("reset.valid", 32'(TxValid), 32'd0);
        chk("reset.full", 32'(SSPTXINTR), 32'd0);
        chk("reset.data", 32'(TxData), 32'h00);
        @(negedge PCLK);
        CLEAR = 1'b0;

        // Single word in and out.
        step(1, 1, 8'hE7, 0, "single.wr");
        chk("single.data", 32'(TxData), 32'hE7);
        step(0, 0, 8'h00, 1, "single.pop");

        // Fill to full, overflow write dropped, drain in order.
        step(1, 1, 8'h11, 0, "fill.11");
        step(1, 1, 8'h22, 0, "fill.22");
        step(1, 1, 8'h33, 0, "fill.33");
        step(1, 1, 8'h44, 0, "fill.44");
        chk("fill.full", 32'(SSPTXINTR), 32'd1);
        step(1, 1, 8'h55, 0, "ovf.55");
        // Blocked write freezes a coincident pop as well.
        step(1, 1, 8'h66, 1, "ovf.66pop");
        chk("ovf.head", 32'(TxData), 32'h11);
        step(0, 0, 8'h00, 1, "drain.1");
        chk("drain.1.notfull", 32'(SSPTXINTR), 32'd0);
        step(0, 0, 8'h00, 1, "drain.2");
        step(0, 0, 8'h00, 1, "drain.3");
        chk("drain.3.data", 32'(TxData), 32'h44);
        step(0, 0, 8'h00, 1, "drain.4");
        // Pop on empty while a write is accepted: only the write happens.
        step(1, 1, 8'hA0, 1, "empty.wrpop");
        chk("empty.wrpop.data", 32'(TxData), 32'hA0);
        step(0, 0, 8'h00, 1, "empty.clean");

        // Simultaneous write and pop at count 2.
        step(1, 1, 8'hA1, 0, "sim.A1");
        step(1, 1, 8'hA2, 0, "sim.A2");
        step(1, 1, 8'hA3, 1, "sim.A3pop");
        chk("sim.head", 32'(TxData), 32'hA2);
        step(0, 0, 8'h00, 1, "sim.pop1");
        chk("sim.next", 32'(TxData), 32'hA3);
        step(0, 0, 8'h00, 1, "sim.pop2");

        // Wrap-around through several write-then-pop pairs.
        for (int i = 1; i <= 6; i++) begin
            step(1, 1, DW'(i), 0, $sformatf("wrap.wr%0d", i));
            chk($sformatf("wrap.data%0d", i), 32'(TxData), 32'(i));
            step(0, 0, 8'h00, 1, $sformatf("wrap.pop%0d", i));
        end

        // Asynchronous clear pulsed between edges at count 3.
        step(1, 1, 8'hB1, 0, "mid.B1");
        step(1, 1, 8'hB2, 0, "mid.B2");
        step(1, 1, 8'hB3, 0, "mid.B3");
        #9;
        CLEAR = 1'b1;
        #5;
        chk("mid.during.valid", 32'(TxValid), 32'd0);
        chk("mid.during.data", 32'(TxData), 32'h00);
        #5;
        CLEAR = 1'b0;
        model_q.delete();
        #1;
        chk("mid.after.valid", 32'(TxValid), 32'd0);
        chk("mid.after.full", 32'(SSPTXINTR), 32'd0);
        step(1, 1, 8'h3A, 0, "mid.3A");
        chk("mid.3A.data", 32'(TxData), 32'h3A);

        // Randomized traffic: write-heavy then pop-heavy phases.
        for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 8),
                 DW'($urandom), 1'($urandom_range(0, 3) == 0), $sformatf("rndw.%0d", i));
        end
        for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 DW'($urandom), 1'($urandom_range(0, 9) < 7), $sformatf("rndp.%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
